// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared helpers for the pipe_reg register slice
package pipe_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`ifndef PIPE_CHECK_DEPTH
`define PIPE_CHECK_DEPTH(d) if ((d) < 1) begin : g_bad_depth $error("pipe_reg: DEPTH must be >= 1"); end
`endif

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one valid/data stage of the pipe_reg slice
module pipe_stage #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             v,
    output logic [WIDTH-1:0] d,
    output logic             rdy_out
);

    // An empty stage always accepts, which is what collapses bubbles.
    assign rdy_out = !v | dn_ready;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            v <= 1'b0;
            d <= RESET_VAL;
        end else if (flush) begin
            v <= 1'b0;
        end else if (rdy_out) begin
            v <= up_valid;
            if (up_valid) begin
                d <= up_data;
            end
        end
    end

endmodule

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - DEPTH-stage valid/ready register slice with flush and occupancy count
module pipe_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int CW = cnt_w(DEPTH);

    `PIPE_CHECK_DEPTH(DEPTH)

    // Per-stage nets live inside each generate block so the ready chain
    // is a series of distinct signals rather than one self-referencing vector.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;
        logic             dn;
        logic             v;
        logic [WIDTH-1:0] d;
        logic             rdy;

        if (i == 0) begin : g_first
            assign up_v = in_valid;
            assign up_d = in_data;
        end else begin : g_rest
            assign up_v = g_stage[i-1].v;
            assign up_d = g_stage[i-1].d;
        end

        if (i == DEPTH - 1) begin : g_last
            assign dn = out_ready;
        end else begin : g_mid
            assign dn = g_stage[i+1].rdy;
        end

        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .clr      (clr),
            .flush    (flush),
            .up_valid (up_v),
            .up_data  (up_d),
            .dn_ready (dn),
            .v        (v),
            .d        (d),
            .rdy_out  (rdy)
        );
    end

    assign in_ready  = g_stage[0].rdy & !flush;
    assign out_valid = g_stage[DEPTH-1].v;
    assign out_data  = g_stage[DEPTH-1].d;

    logic xfer_in;
    logic xfer_out;

    assign xfer_in  = in_valid & in_ready;
    assign xfer_out = out_valid & out_ready;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (xfer_in && !xfer_out) begin
            count <= count + CW'(1);
        end else if (xfer_out && !xfer_in) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_pipe_reg.sv
// tb/tb_pipe_reg.sv - directed self-checking bench for pipe_reg (WIDTH=8, DEPTH=3)
module tb_pipe_reg;

    logic       clk = 1'b0;
    logic       clr;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_reg #(
        .WIDTH     (8),
        .DEPTH     (3),
        .RESET_VAL (8'hA5)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        clr = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL reset_od got %h exp a5", out_data); end
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ir got %b exp 1", in_ready); end
        cyc; cyc;
        clr = 1'b0;
        cyc;
    endtask

    task automatic test_streaming;
        logic       e_ov [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] e_od [6] = '{8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h03};
        logic [1:0] e_ct [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k < 3) begin
                in_valid = 1'b1; in_data = 8'(k + 1);
                #1;
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ir k=%0d got %b exp 1", k, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            cyc;
            checks++; if (out_valid !== e_ov[k]) begin errors++; $display("FAIL stream_ov k=%0d got %b exp %b", k, out_valid, e_ov[k]); end
            checks++; if (out_data !== e_od[k]) begin errors++; $display("FAIL stream_od k=%0d got %h exp %h", k, out_data, e_od[k]); end
            checks++; if (count !== e_ct[k]) begin errors++; $display("FAIL stream_cnt k=%0d got %0d exp %0d", k, count, e_ct[k]); end
        end
    endtask

    task automatic test_back_pressure;
        logic [7:0] e_od [4] = '{8'h11, 8'h12, 8'h13, 8'h13};
        logic       e_ov [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] e_ct [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 8'(8'h10 + k);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ir k=%0d got %b exp 1", k, in_ready); end
            cyc;
        end
        in_data = 8'h13;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ir got %b exp 0", in_ready); end
        checks++; if (count !== 2'd3) begin errors++; $display("FAIL bp_full_cnt got %0d exp 3", count); end
        cyc;
        checks++; if (count !== 2'd3) begin errors++; $display("FAIL bp_hold_cnt got %0d exp 3", count); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_rel_ir got %b exp 1", in_ready); end
        checks++; if (out_data !== 8'h10) begin errors++; $display("FAIL bp_first_od got %h exp 10", out_data); end
        cyc;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_valid !== e_ov[k]) begin errors++; $display("FAIL bp_ov k=%0d got %b exp %b", k, out_valid, e_ov[k]); end
            checks++; if (out_data !== e_od[k]) begin errors++; $display("FAIL bp_od k=%0d got %h exp %h", k, out_data, e_od[k]); end
            checks++; if (count !== e_ct[k]) begin errors++; $display("FAIL bp_cnt k=%0d got %0d exp %0d", k, count, e_ct[k]); end
            cyc;
        end
    endtask

    task automatic test_bubble;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h20; cyc;
        in_valid = 1'b0; cyc; cyc;
        in_valid = 1'b1; in_data = 8'h21; cyc;
        in_valid = 1'b0; cyc;
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL bub_cnt got %0d exp 2", count); end
        checks++; if (out_data !== 8'h20 || out_valid !== 1'b1) begin errors++; $display("FAIL bub_head got %h/%b exp 20/1", out_data, out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bub_ir got %b exp 1", in_ready); end
        out_ready = 1'b1;
        cyc;
        checks++; if (out_data !== 8'h21 || out_valid !== 1'b1) begin errors++; $display("FAIL bub_next got %h/%b exp 21/1", out_data, out_valid); end
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL bub_cnt1 got %0d exp 1", count); end
        cyc;
        checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL bub_empty got %b/%0d exp 0/0", out_valid, count); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 8'(8'h50 + k); cyc;
        end
        flush = 1'b1; in_data = 8'h30;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_ir got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fl_ov_cur got %b exp 1", out_valid); end
        cyc;
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL fl_cnt got %0d exp 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_ov got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h50) begin errors++; $display("FAIL fl_od_hold got %h exp 50", out_data); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_stale k=%0d got %b exp 0", k, out_valid); end
        end
    endtask

    task automatic test_full_simul;
        logic [7:0] e_od [3] = '{8'h61, 8'h62, 8'h40};
        logic [1:0] e_ct [3] = '{2'd3, 2'd2, 2'd1};
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 8'(8'h60 + k); cyc;
        end
        out_ready = 1'b1; in_data = 8'h40;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fs_ir got %b exp 1", in_ready); end
        checks++; if (out_data !== 8'h60) begin errors++; $display("FAIL fs_head got %h exp 60", out_data); end
        cyc;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (out_data !== e_od[k] || out_valid !== 1'b1) begin errors++; $display("FAIL fs_od k=%0d got %h/%b exp %h/1", k, out_data, out_valid, e_od[k]); end
            checks++; if (count !== e_ct[k]) begin errors++; $display("FAIL fs_cnt k=%0d got %0d exp %0d", k, count, e_ct[k]); end
            cyc;
        end
        checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL fs_empty got %b/%0d exp 0/0", out_valid, count); end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h70; cyc;
        in_data = 8'h71; cyc;
        in_valid = 1'b0;
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL rm_pre_cnt got %0d exp 2", count); end
        #2 clr = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_ov got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL rm_od got %h exp a5", out_data); end
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL rm_cnt got %0d exp 0", count); end
        @(negedge clk);
        clr = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_stale k=%0d got %b exp 0", k, out_valid); end
        end
    endtask

    initial begin
        test_reset;
        test_streaming;
        test_back_pressure;
        test_bubble;
        test_flush;
        test_full_simul;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_reg.md
Name: pipe_reg

Overview:
- Parametrised multi-stage pipeline register: DEPTH stages of WIDTH-bit data, each stage a valid bit plus an enabled data register.
- Valid/ready handshake at both ends. Bubbles collapse: an empty stage accepts even when downstream is stalled.
- Adds synchronous flush and an occupancy count.
- Sits between datapath units wherever a register slice with back-pressure is needed. Replaces hand-instantiated banks of single-bit flops.

Parameters:
- WIDTH, 32, data width in bits (>=1).
- DEPTH, 2, number of register stages (>=1; DEPTH=0 rejected at elaboration).
- RESET_VAL, 0, WIDTH-bit value loaded into every data register on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clr  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous flush: invalidate all stages.
- in_valid  in  1  upstream data valid.
- in_ready  out  1  pipe can accept in_data this cycle.
- in_data  in  WIDTH  upstream data.
- out_valid  out  1  stage DEPTH-1 holds valid data.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  WIDTH  data of stage DEPTH-1.
- count  out  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Reset (clr=1, async, any time, including mid-transfer): all valid bits=0, all data registers=RESET_VAL, count=0. out_valid=0 and out_data=RESET_VAL immediately.
- Stage i (0=input, DEPTH-1=output) has v[i] and d[i].
- Downstream ready:
  - r[DEPTH] = out_ready.
  - r[i] = !v[i] | r[i+1]; combinational chain, no registered ready.
- in_ready = r[0] & !flush.
- Stage i loads when r[i]=1:
  - v[i] <= upstream valid; upstream valid is in_valid for stage 0, else v[i-1].
  - d[i] <= upstream data, only when upstream valid=1; otherwise d[i] holds (no toggle on bubbles).
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Latency: an accepted word appears at out_valid exactly DEPTH cycles later if never stalled.
- Throughput: 1 word/cycle when out_ready stays high.
- Stall: with out_ready=0, words advance into empty stages until all DEPTH stages are valid. Then in_ready=0 and all d[i] hold.
- Simultaneous in/out when full: out_ready=1 frees the output stage, the chain propagates, in_ready=1, and a new word is accepted the same cycle. count unchanged.
- Flush (sync, priority over every handshake):
  - Next edge: all v[i]=0, count=0; data registers hold.
  - in_ready=0 during the flush cycle, so no input is accepted.
  - out_valid still reflects the current state, so a downstream transfer may complete that same cycle.
- count = popcount(v), registered. Update rule: +1 on transfer in only, -1 on transfer out only, unchanged on both or neither, 0 on flush. Never exceeds DEPTH.
- Data is never reordered, duplicated or dropped, except by flush or clr.
- DEPTH=1: single-stage slice, in_ready = !v[0] | out_ready.

Decomposition:
- Package pipe_pkg:
  - function cnt_w(depth) returning $clog2(depth+1).
  - Elaboration check macro/assertion for DEPTH>=1.
- One sub-module pipe_stage (params WIDTH, RESET_VAL; ports clk, clr, flush, up_valid, up_data, dn_ready, v, d, rdy_out), instantiated DEPTH times in a generate loop.
- count logic stays in the top level.

Test Plan (WIDTH=8, DEPTH=3, RESET_VAL=8'hA5):
- Reset: clr pulsed mid-stream with 2 words in flight -> immediately out_valid=0, out_data=8'hA5, count=0; no stale word emerges afterwards.
- Streaming: out_ready=1; in 8'h01,8'h02,8'h03 on consecutive cycles -> out_valid rises at cycle 3 after first accept; out 01,02,03 consecutively; count 1,2,3 then steady at 3 while streaming.
- Back-pressure: out_ready=0; push 8'h10,8'h11,8'h12,8'h13 -> first three accepted, in_ready=0 on 4th, count=3. Raise out_ready -> 10,11,12 out in order; 13 accepted the cycle out_ready rises.
- Bubble collapse: push 8'h20, idle 2 cycles, push 8'h21, out_ready=0 -> both reside in stages 2,1 with count=2; release -> 20 then 21 back-to-back.
- Flush: 3 words held, flush=1 with in_valid=1, in_data=8'h30 -> in_ready=0, 30 not accepted; next cycle count=0, out_valid=0.
- Full + simultaneous in/out: pipe full, out_ready=1, in_valid=1 (8'h40) -> one out, 40 accepted same cycle, count stays 3; order preserved.
